// File: rtl/sonic_vc_rx_pkt_monitor.sv
// Receive-side packet monitor: absorbs a ready-latency-1 stream into a 4-entry elastic
// buffer, re-presents it at ready latency 0, and checks framing, length and counts.
module sonic_vc_rx_pkt_monitor #(
    parameter int DATA_W    = 128,
    parameter int EMPTY_W   = 2,
    parameter int LEN_W     = 16,
    parameter int MAX_WORDS = 2048,
    parameter int CNT_W     = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  sink_data,
    input  logic [EMPTY_W-1:0] sink_empty,
    input  logic               sink_startofpacket,
    input  logic               sink_endofpacket,
    input  logic               sink_valid,
    output logic               sink_ready,
    output logic [DATA_W-1:0]  source_data,
    output logic [EMPTY_W-1:0] source_empty,
    output logic               source_startofpacket,
    output logic               source_endofpacket,
    output logic               source_valid,
    input  logic               source_ready,
    output logic               stat_valid,
    output logic [LEN_W-1:0]   stat_len,
    output logic [1:0]         stat_err,
    input  logic               clear_counters,
    output logic [CNT_W-1:0]   pkt_count,
    output logic [CNT_W-1:0]   err_count
);

    localparam int                 BEAT_W     = DATA_W + EMPTY_W + 2;
    localparam logic [LEN_W-1:0]   LEN_SAT    = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0]   MAX_LEN    = LEN_W'(MAX_WORDS);
    localparam logic [LEN_W-1:0]   BEAT_WORDS = LEN_W'(DATA_W / 32);

    typedef enum logic {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic [BEAT_W-1:0] buf_mem_r [4];
    logic [1:0]        wr_ptr_r, rd_ptr_r;
    logic [2:0]        used_r, used_nxt_s;
    logic              sink_ready_r;
    state_t            state_r;
    logic [LEN_W-1:0]  words_r;
    logic              pend_valid_r;
    logic [LEN_W-1:0]  pend_len_r;
    logic [1:0]        pend_err_r;
    logic              stat_valid_r;
    logic [LEN_W-1:0]  stat_len_r;
    logic [1:0]        stat_err_r;
    logic [CNT_W-1:0]  pkt_count_r, err_count_r;

    logic              in_pkt_s, wr_en_s, wr_ok_s, rd_en_s, stray_s;
    logic [LEN_W:0]    words_sum_s;
    logic [LEN_W-1:0]  words_inc_s, done_len_s;
    logic              close_v_s, done_v_s;
    logic [1:0]        close_err_s, done_err_s;
    logic              emit_v_s, keep_v_s;
    logic [LEN_W-1:0]  emit_len_s, keep_len_s;
    logic [1:0]        emit_err_s, keep_err_s;
    logic [1:0]        err_inc_s;
    logic              pkt_inc_s;
    logic [BEAT_W-1:0] head_s;

    // Beat classification and completion candidates for the accepted beat
    always_comb begin
        in_pkt_s    = (state_r == ST_IN_PKT);
        words_sum_s = {1'b0, words_r} + {1'b0, BEAT_WORDS};
        words_inc_s = words_sum_s[LEN_W] ? LEN_SAT : words_sum_s[LEN_W-1:0];
        wr_en_s     = sink_valid & ~reset & (sink_startofpacket | in_pkt_s);
        stray_s     = sink_valid & ~reset & ~sink_startofpacket & ~in_pkt_s;
        close_v_s   = sink_valid & ~reset & sink_startofpacket & in_pkt_s;
        done_v_s    = wr_en_s & sink_endofpacket;
        done_len_s  = (sink_startofpacket ? BEAT_WORDS : words_inc_s) - LEN_W'(sink_empty);
        close_err_s = {(words_r > MAX_LEN), 1'b1};
        done_err_s  = {(done_len_s > MAX_LEN), 1'b0};
    end

    // A SOP that truncates a packet and also carries EOP yields two statuses;
    // the younger one waits in the pending slot (one slot always suffices).
    always_comb begin
        emit_v_s   = 1'b0;
        emit_len_s = '0;
        emit_err_s = 2'b00;
        keep_v_s   = 1'b0;
        keep_len_s = '0;
        keep_err_s = 2'b00;
        if (pend_valid_r) begin
            emit_v_s   = 1'b1;
            emit_len_s = pend_len_r;
            emit_err_s = pend_err_r;
            keep_v_s   = close_v_s | done_v_s;
            keep_len_s = close_v_s ? words_r : done_len_s;
            keep_err_s = close_v_s ? close_err_s : done_err_s;
        end else if (close_v_s) begin
            emit_v_s   = 1'b1;
            emit_len_s = words_r;
            emit_err_s = close_err_s;
            keep_v_s   = done_v_s;
            keep_len_s = done_len_s;
            keep_err_s = done_err_s;
        end else if (done_v_s) begin
            emit_v_s   = 1'b1;
            emit_len_s = done_len_s;
            emit_err_s = done_err_s;
        end else begin
            emit_v_s   = 1'b0;
        end
    end

    // Buffer handshake and occupancy bookkeeping
    always_comb begin
        rd_en_s    = (used_r != 3'd0) & source_ready;
        wr_ok_s    = wr_en_s & ((used_r != 3'd4) | rd_en_s);
        used_nxt_s = used_r + {2'b00, wr_ok_s} - {2'b00, rd_en_s};
        head_s     = buf_mem_r[rd_ptr_r];
        pkt_inc_s  = stat_valid_r & (stat_err_r == 2'b00);
        err_inc_s  = {1'b0, stat_valid_r & (stat_err_r != 2'b00)} + {1'b0, stray_s};
    end

    // Buffer storage; contents need no reset since pointers define validity
    always_ff @(posedge clock) begin
        if (wr_ok_s) begin
            buf_mem_r[wr_ptr_r] <= {sink_data, sink_empty, sink_startofpacket, sink_endofpacket};
        end
    end

    // Buffer pointers, occupancy and the registered sink_ready
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r     <= 2'd0;
            rd_ptr_r     <= 2'd0;
            used_r       <= 3'd0;
            sink_ready_r <= 1'b0;
        end else begin
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + 2'd1;
            if (rd_en_s) rd_ptr_r <= rd_ptr_r + 2'd1;
            used_r       <= used_nxt_s;
            sink_ready_r <= (used_nxt_s <= 3'd2);
        end
    end

    // Framing FSM with word accumulation and status registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            words_r      <= '0;
            pend_valid_r <= 1'b0;
            pend_len_r   <= '0;
            pend_err_r   <= 2'b00;
            stat_valid_r <= 1'b0;
            stat_len_r   <= '0;
            stat_err_r   <= 2'b00;
        end else begin
            if (sink_valid) begin
                case (state_r)
                    ST_IDLE: begin
                        if (sink_startofpacket) begin
                            words_r <= BEAT_WORDS;
                            state_r <= sink_endofpacket ? ST_IDLE : ST_IN_PKT;
                        end
                    end
                    ST_IN_PKT: begin
                        if (sink_startofpacket) begin
                            words_r <= BEAT_WORDS;
                            state_r <= sink_endofpacket ? ST_IDLE : ST_IN_PKT;
                        end else begin
                            words_r <= words_inc_s;
                            state_r <= sink_endofpacket ? ST_IDLE : ST_IN_PKT;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
            pend_valid_r <= keep_v_s;
            pend_len_r   <= keep_len_s;
            pend_err_r   <= keep_err_s;
            stat_valid_r <= emit_v_s;
            if (emit_v_s) begin
                stat_len_r <= emit_len_s;
                stat_err_r <= emit_err_s;
            end
        end
    end

    // Saturating statistics; clear wins over any increment
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_count_r <= '0;
            err_count_r <= '0;
        end else if (clear_counters) begin
            pkt_count_r <= '0;
            err_count_r <= '0;
        end else begin
            pkt_count_r <= sat_add(pkt_count_r, {1'b0, pkt_inc_s});
            err_count_r <= sat_add(err_count_r, err_inc_s);
        end
    end

    assign sink_ready           = sink_ready_r;
    assign source_valid         = (used_r != 3'd0);
    assign source_data          = head_s[BEAT_W-1 -: DATA_W];
    assign source_empty         = head_s[EMPTY_W+1:2];
    assign source_startofpacket = head_s[1];
    assign source_endofpacket   = head_s[0];
    assign stat_valid           = stat_valid_r;
    assign stat_len             = stat_len_r;
    assign stat_err             = stat_err_r;
    assign pkt_count            = pkt_count_r;
    assign err_count            = err_count_r;

endmodule

// File: doc/sonic_vc_rx_pkt_monitor.md
Name: sonic_vc_rx_pkt_monitor

Overview:
Downstream stage of the VC receive FIFO. Consumes its 128-bit Avalon-ST output, which has ready latency 1: valid is registered one cycle after ready. Re-presents the stream to the next stage as a standard ready-latency-0 interface through a 4-entry elastic buffer. Checks SOP/EOP framing, measures packet length in 32-bit words, and emits one status pulse per packet plus saturating good and error counters.

Parameters:
DATA_W, 128, stream data width (multiple of 32)
EMPTY_W, 2, empty field width; counts unused 32-bit symbols in the EOP beat
LEN_W, 16, packet length width in 32-bit words
MAX_WORDS, 2048, longest legal packet in words
CNT_W, 32, statistics counter width

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
sink_data  in  DATA_W  beat data from RX FIFO
sink_empty  in  EMPTY_W  unused words in EOP beat
sink_startofpacket  in  1  SOP
sink_endofpacket  in  1  EOP
sink_valid  in  1  beat valid (ready latency 1)
sink_ready  out  1  to RX FIFO source_ready
source_data  out  DATA_W  forwarded data
source_empty  out  EMPTY_W  forwarded empty
source_startofpacket  out  1  forwarded SOP
source_endofpacket  out  1  forwarded EOP
source_valid  out  1  head of buffer valid
source_ready  in  1  downstream ready (ready latency 0)
stat_valid  out  1  one-cycle per-packet status pulse
stat_len  out  LEN_W  packet length in words
stat_err  out  2  bit0 missing-EOP, bit1 oversize
clear_counters  in  1  synchronous counter clear
pkt_count  out  CNT_W  error-free packets
err_count  out  CNT_W  errored packets plus dropped stray beats

Behaviour:
- Reset, and the first cycle after it: sink_ready=0, source_valid=0, stat_valid=0, stat_len=0, stat_err=0, counters=0, buffer empty, framing state IDLE. Beats with sink_valid during reset are ignored. Reset mid-packet flushes the buffer and emits no status.
- Sink side: a beat is accepted on every cycle sink_valid=1; the block never stalls a valid beat.
- sink_ready = !reset & (used <= 2), where used is the registered buffer occupancy (0..4). This guarantees space for one in-flight beat plus one newly requested beat.
- Source side: source_valid = (used != 0); source_* show the buffer head. A transfer occurs when source_valid & source_ready. Simultaneous write and read leaves used unchanged. Minimum latency is sink beat at cycle t -> source_valid at t+1.
- Framing FSM, evaluated on each accepted beat:
  - IDLE + SOP: go to IN_PKT and load words = 4. If EOP is also set, the packet completes immediately and the state stays IDLE.
  - IDLE + no SOP: stray beat. It is not written to the buffer, err_count increments, and no status is emitted.
  - IN_PKT + no SOP: words += 4. On EOP the packet completes and the state returns to IDLE.
  - IN_PKT + SOP: the previous packet closes with stat_err bit0=1, using the words accumulated so far. The new beat starts a new packet and is forwarded normally.
- Completion length = words - sink_empty. sink_empty is ignored on non-EOP beats.
- Length arithmetic: the words counter saturates at 2^LEN_W-1. Oversize (bit1) is set when the final length exceeds MAX_WORDS. Oversized packets are still forwarded.
- Status: stat_valid pulses for one cycle, the cycle after the completing beat is accepted. stat_len and stat_err hold their values until the next pulse.
- Counters:
  - pkt_count increments on each pulse with stat_err=0.
  - err_count increments on each pulse with stat_err!=0 and on each stray beat. When both occur in the same cycle it increments by 2.
  - Both counters saturate at all-ones.
  - clear_counters has priority over any increment in the same cycle.

Test Plan:
- Single-beat packet, SOP=EOP=1, empty=1 -> source beat at t+1; stat_valid at t+1 with stat_len=3, stat_err=0; pkt_count=1.
- 5-beat packet streamed back-to-back with source_ready=1, empty=2 on EOP -> 5 contiguous source beats; stat_len=18; sink_ready never deasserts.
- source_ready=0 for 10 cycles while the FIFO model streams at ready latency 1 -> used peaks at 4 and never overflows; sink_ready drops when used>=3; no beat is lost, duplicated or reordered after release.
- Beat without SOP while IDLE -> not forwarded; err_count=1; no stat pulse.
- SOP, 2 body beats, then new SOP+EOP -> stat pulse with stat_len=12, stat_err=01, followed by a clean pulse for the second packet; err_count=1, pkt_count=1.
- 600-beat packet with MAX_WORDS=2048 -> stat_len=2400, stat_err=10. Reset asserted mid-packet -> outputs return to reset values and no stat pulse follows. clear_counters coincident with a pulse -> counters read 0.
